// File: rtl/dmem_responder.sv
// Multi-cycle data memory: one outstanding load/store, fixed LATENCY from acceptance to commit.
// Define MEM_RESP_ADDR_CHECK_EN to flag word addresses >= DEPTH instead of aliasing them.
module dmem_responder #(
    parameter int unsigned DEPTH   = 16384,
    parameter int unsigned LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_write,
    output logic        resp_err,
    output logic        busy
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          resp_write_q, resp_write_d;
    logic          commit;
    logic          mem_we;
    logic [31:0]   mem_rdata;
    logic          unused_addr_bits;

    logic [31:0]   mem [DEPTH];

    assign mem_rdata = mem[idx_q];

`ifdef MEM_RESP_ADDR_CHECK_EN
    logic oor_q, oor_d;
    logic resp_err_q, resp_err_d;
    logic req_oor;

    assign req_oor          = |req_addr[31:AW+2];
    assign unused_addr_bits = ^req_addr[1:0];
    assign resp_err         = resp_err_q;
`else
    assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
    assign resp_err         = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_write_d = resp_write_q;
        commit       = 1'b0;
`ifdef MEM_RESP_ADDR_CHECK_EN
        oor_d        = oor_q;
        resp_err_d   = resp_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    idx_d   = req_addr[AW+1:2];
                    wdata_d = req_wdata;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = S_WAIT;
`ifdef MEM_RESP_ADDR_CHECK_EN
                    oor_d   = req_oor;
`endif
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    commit       = 1'b1;
                    state_d      = S_RESP;
                    resp_write_d = wr_q;
                    resp_rdata_d = wr_q ? wdata_q : mem_rdata;
`ifdef MEM_RESP_ADDR_CHECK_EN
                    resp_err_d   = oor_q;
                    if (oor_q) resp_rdata_d = '0;
`endif
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A reset landing on the commit edge must drop the store, so gate the write with reset.
`ifdef MEM_RESP_ADDR_CHECK_EN
    assign mem_we = commit && wr_q && !oor_q && reset;
`else
    assign mem_we = commit && wr_q && reset;
`endif

    always_ff @(posedge clk) begin
        if (mem_we) mem[idx_q] <= wdata_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            resp_rdata_q <= '0;
            resp_write_q <= 1'b0;
`ifdef MEM_RESP_ADDR_CHECK_EN
            oor_q        <= 1'b0;
            resp_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_write_q <= resp_write_d;
`ifdef MEM_RESP_ADDR_CHECK_EN
            oor_q        <= oor_d;
            resp_err_q   <= resp_err_d;
`endif
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_write = resp_write_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=4/DEPTH=16384 and LATENCY=1/DEPTH=64 instances vs a word-array model.
module tb_dmem_responder;
    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        w;
        logic        e;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v4, w4, rdy4, rv4, rw4, re4, bz4;
    logic [31:0] a4, d4, rd4;
    logic        v1, w1, rdy1, rv1, rw1, re1, bz1;
    logic [31:0] a1, d1, rd1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int    acc4_q[$], acc1_q[$];
    resp_t resp4_q[$], resp1_q[$];
    resp_t m4, m1;

    logic [31:0] mem4_m [int unsigned];
    logic [31:0] mem1_m [int unsigned];

    dmem_responder #(.DEPTH(16384), .LATENCY(4)) dut4 (
        .clk(clk), .reset(rst_n), .req_valid(v4), .req_ready(rdy4), .req_write(w4),
        .req_addr(a4), .req_wdata(d4), .resp_valid(rv4), .resp_rdata(rd4),
        .resp_write(rw4), .resp_err(re4), .busy(bz4));

    dmem_responder #(.DEPTH(64), .LATENCY(1)) dut1 (
        .clk(clk), .reset(rst_n), .req_valid(v1), .req_ready(rdy1), .req_write(w1),
        .req_addr(a1), .req_wdata(d1), .resp_valid(rv1), .resp_rdata(rd1),
        .resp_write(rw1), .resp_err(re1), .busy(bz1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Acceptance edge is the edge after a negedge seeing valid&ready; responses tagged with commit edge.
    always @(negedge clk) begin
        if (rst_n && v4 && rdy4) acc4_q.push_back(cyc + 1);
        if (rst_n && v1 && rdy1) acc1_q.push_back(cyc + 1);
        if (rv4) begin
            m4.cyc = cyc; m4.rdata = rd4; m4.w = rw4; m4.e = re4;
            resp4_q.push_back(m4);
        end
        if (rv1) begin
            m1.cyc = cyc; m1.rdata = rd1; m1.w = rw1; m1.e = re1;
            resp1_q.push_back(m1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void model_op(input bit l1, input bit w, input logic [31:0] a,
                                     input logic [31:0] d, output logic [31:0] rd, output bit err);
        int unsigned depth = l1 ? 64 : 16384;
        int unsigned word  = a >> 2;
        int unsigned idx;
        err = 1'b0;
        rd  = 'x;
`ifdef MEM_RESP_ADDR_CHECK_EN
        if (word >= depth) begin
            err = 1'b1;
            rd  = '0;
            return;
        end
`endif
        idx = word % depth;
        if (w) begin
            rd = d;
            if (l1) mem1_m[idx] = d; else mem4_m[idx] = d;
        end else if (l1) begin
            if (mem1_m.exists(idx)) rd = mem1_m[idx];
        end else begin
            if (mem4_m.exists(idx)) rd = mem4_m[idx];
        end
    endfunction

    task automatic issue(input bit l1, input bit w, input logic [31:0] a, input logic [31:0] d,
                         output int acc);
        int n0;
        bit done = 1'b0;
        n0  = l1 ? acc1_q.size() : acc4_q.size();
        acc = -1;
        @(posedge clk); #2;
        if (l1) begin v1 = 1'b1; w1 = w; a1 = a; d1 = d; end
        else    begin v4 = 1'b1; w4 = w; a4 = a; d4 = d; end
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk); #1;
            if ((l1 ? acc1_q.size() : acc4_q.size()) > n0) begin
                done = 1'b1;
                acc  = l1 ? acc1_q[$] : acc4_q[$];
            end
        end
        @(posedge clk); #2;
        if (l1) v1 = 1'b0; else v4 = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL accept_timeout: got no acceptance, required one within 40 cycles");
        end
    endtask

    task automatic get_resp(input bit l1, output resp_t r, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if ((l1 ? resp1_q.size() : resp4_q.size()) != 0) ok = 1'b1;
            else begin @(negedge clk); #1; end
        end
        if (ok) r = l1 ? resp1_q.pop_front() : resp4_q.pop_front();
    endtask

    task automatic xact(input bit l1, input bit w, input logic [31:0] a, input logic [31:0] d,
                        output int acc, output resp_t r, output bit ok);
        issue(l1, w, a, d, acc);
        get_resp(l1, r, ok);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        v4 = 0; w4 = 0; a4 = 0; d4 = 0;
        v1 = 0; w1 = 0; a1 = 0; d1 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", rdy4); end
        checks++; if (bz4 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bz4); end
        checks++; if (rv4 !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", rv4); end
        checks++; if (rd4 !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rd4); end
        checks++; if (rw4 !== 1'b0 || re4 !== 1'b0) begin errors++; $display("FAIL reset_write_err: got %b%b want 00", rw4, re4); end
        checks++; if (rdy1 !== 1'b1 || bz1 !== 1'b0) begin errors++; $display("FAIL reset_l1_ready_busy: got %b%b want 10", rdy1, bz1); end
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    task automatic test_store_timing;
        int acc; resp_t r; bit ok, err; logic [31:0] exp;
        issue(0, 1, 32'h10, 32'hDEADBEEF, acc);
        model_op(0, 1, 32'h10, 32'hDEADBEEF, exp, err);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (rdy4 !== (k == 5) || bz4 !== (k != 5)) begin
                errors++; $display("FAIL store_ready_c%0d: ready/busy %b%b want %b%b", k, rdy4, bz4, k == 5, k != 5);
            end
            checks++;
            if (rv4 !== (k == 4)) begin
                errors++; $display("FAIL store_resp_valid_c%0d: got %b want %b", k, rv4, k == 4);
            end
        end
        get_resp(0, r, ok);
        checks++;
        if (!ok || r.cyc != acc + 4 || r.rdata !== exp || r.w !== 1'b1) begin
            errors++; $display("FAIL store_resp: ok=%b edge=%0d data=%h w=%b want edge=%0d data=%h w=1", ok, r.cyc, r.rdata, r.w, acc + 4, exp);
        end
    endtask

    task automatic test_load_after_store;
        int acc; resp_t r; bit ok, err; logic [31:0] exp;
        xact(0, 0, 32'h13, 32'h0, acc, r, ok);
        model_op(0, 0, 32'h13, 32'h0, exp, err);
        checks++;
        if (!ok || r.cyc != acc + 4 || r.rdata !== exp || r.w !== 1'b0 || r.e !== err) begin
            errors++; $display("FAIL load_after_store: ok=%b lat=%0d data=%h w=%b want lat=4 data=%h w=0", ok, r.cyc - acc, r.rdata, r.w, exp);
        end
    endtask

    task automatic test_random;
        int acc; resp_t r; bit ok, w, err; logic [31:0] a, d, exp;
        int unsigned word;
        for (int n = 0; n < 24; n++) begin
            word = 128 + $urandom_range(0, 7);
            w    = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 5) == 0) begin
                word = word + 16384;
                w    = 1'b1;
            end
            if (!w && !mem4_m.exists(word)) w = 1'b1;
            a = (word << 2) | $urandom_range(0, 3);
            d = $urandom;
            xact(0, w, a, d, acc, r, ok);
            model_op(0, w, a, d, exp, err);
            checks++;
            if (!ok || r.cyc != acc + 4) begin
                errors++; $display("FAIL rand%0d_latency: ok=%b lat=%0d want 4", n, ok, r.cyc - acc);
            end
            checks++;
            if (r.rdata !== exp || r.w !== w || r.e !== err) begin
                errors++; $display("FAIL rand%0d_resp: addr=%h data=%h w=%b e=%b want data=%h w=%b e=%b", n, a, r.rdata, r.w, r.e, exp, w, err);
            end
        end
    endtask

    task automatic test_back_to_back;
        int acc, n0; resp_t r, ra, rb; bit ok, oka, okb, err, got; logic [31:0] ea, eb;
        xact(0, 1, 32'h80, 32'h0BAD_C0DE, acc, r, ok);
        model_op(0, 1, 32'h80, 32'h0BAD_C0DE, ea, err);
        checks++;
        if (!ok || r.rdata !== ea) begin errors++; $display("FAIL b2b_prep: data=%h want %h", r.rdata, ea); end
        n0 = acc4_q.size();
        @(posedge clk); #2;
        v4 = 1'b1; w4 = 1'b0; a4 = 32'h10;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin @(negedge clk); #1; got = acc4_q.size() > n0; end
        @(posedge clk); #2;
        a4 = 32'h80;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin @(negedge clk); #1; got = acc4_q.size() > n0 + 1; end
        @(posedge clk); #2;
        v4 = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (acc4_q.size() != n0 + 2) begin
            errors++; $display("FAIL b2b_accepts: got %0d want 2", acc4_q.size() - n0);
        end else begin
            checks++;
            if (acc4_q[n0 + 1] - acc4_q[n0] != 6) begin
                errors++; $display("FAIL b2b_spacing: got %0d want 6", acc4_q[n0 + 1] - acc4_q[n0]);
            end
            checks++;
            if (resp4_q.size() != 2) begin
                errors++; $display("FAIL b2b_pulses: got %0d want 2", resp4_q.size());
            end else begin
                model_op(0, 0, 32'h10, 32'h0, ea, err);
                model_op(0, 0, 32'h80, 32'h0, eb, err);
                get_resp(0, ra, oka);
                get_resp(0, rb, okb);
                checks++;
                if (ra.rdata !== ea || ra.cyc != acc4_q[n0] + 4 || rb.rdata !== eb || rb.cyc != acc4_q[n0 + 1] + 4) begin
                    errors++; $display("FAIL b2b_data: got %h/%h want %h/%h", ra.rdata, rb.rdata, ea, eb);
                end
            end
        end
        resp4_q.delete();
    endtask

    task automatic test_reset_wait;
        int acc; resp_t r; bit ok, err; logic [31:0] exp;
        xact(0, 1, 32'h20, 32'h5555, acc, r, ok);
        model_op(0, 1, 32'h20, 32'h5555, exp, err);
        checks++;
        if (!ok || r.rdata !== exp) begin errors++; $display("FAIL rst_prep: data=%h want %h", r.rdata, exp); end
        issue(0, 1, 32'h20, 32'h1234, acc);
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rdy4 !== 1'b1 || bz4 !== 1'b0 || rv4 !== 1'b0 || rd4 !== 32'h0 || rw4 !== 1'b0 || re4 !== 1'b0) begin
            errors++; $display("FAIL rst_wait_outputs: rdy=%b busy=%b rv=%b rd=%h rw=%b re=%b want 1 0 0 0 0 0", rdy4, bz4, rv4, rd4, rw4, re4);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (resp4_q.size() != 0) begin
            errors++; $display("FAIL rst_wait_no_resp: got %0d pulses want 0", resp4_q.size());
        end
        resp4_q.delete();
        xact(0, 0, 32'h20, 32'h0, acc, r, ok);
        model_op(0, 0, 32'h20, 32'h0, exp, err);
        checks++;
        if (!ok || r.rdata !== exp) begin
            errors++; $display("FAIL rst_wait_load: data=%h want %h", r.rdata, exp);
        end
    endtask

    task automatic test_out_of_range;
        int acc; resp_t r; bit ok, err; logic [31:0] exp;
        xact(0, 1, 32'h0, 32'h1111_1111, acc, r, ok);
        model_op(0, 1, 32'h0, 32'h1111_1111, exp, err);
        checks++;
        if (!ok || r.rdata !== exp || r.e !== 1'b0) begin errors++; $display("FAIL oor_prep: data=%h e=%b want %h 0", r.rdata, r.e, exp); end
        xact(0, 1, 32'h0001_0000, 32'hCAFE_F00D, acc, r, ok);
        model_op(0, 1, 32'h0001_0000, 32'hCAFE_F00D, exp, err);
        checks++;
        if (!ok || r.rdata !== exp || r.e !== err || r.w !== 1'b1) begin
            errors++; $display("FAIL oor_store: data=%h e=%b want %h %b", r.rdata, r.e, exp, err);
        end
        xact(0, 0, 32'h0, 32'h0, acc, r, ok);
        model_op(0, 0, 32'h0, 32'h0, exp, err);
        checks++;
        if (!ok || r.rdata !== exp || r.e !== 1'b0) begin
            errors++; $display("FAIL oor_word0: data=%h e=%b want %h 0", r.rdata, r.e, exp);
        end
    endtask

    task automatic test_latency1;
        int acc, acc2; resp_t r; bit ok, err; logic [31:0] exp;
        xact(1, 1, 32'h40, 32'hA5A5_A5A5, acc, r, ok);
        model_op(1, 1, 32'h40, 32'hA5A5_A5A5, exp, err);
        checks++;
        if (!ok || r.cyc != acc + 1 || r.rdata !== exp || r.w !== 1'b1) begin
            errors++; $display("FAIL lat1_store: lat=%0d data=%h want lat=1 data=%h", r.cyc - acc, r.rdata, exp);
        end
        xact(1, 0, 32'h40, 32'h0, acc2, r, ok);
        model_op(1, 0, 32'h40, 32'h0, exp, err);
        checks++;
        if (acc2 != acc + 3) begin
            errors++; $display("FAIL lat1_next_accept: got +%0d want +3", acc2 - acc);
        end
        checks++;
        if (!ok || r.cyc != acc2 + 1 || r.rdata !== exp || r.w !== 1'b0) begin
            errors++; $display("FAIL lat1_load: lat=%0d data=%h want lat=1 data=%h", r.cyc - acc2, r.rdata, exp);
        end
    endtask

    initial begin
        test_reset();
        test_store_timing();
        test_load_after_store();
        test_back_to_back();
        test_reset_wait();
        test_out_of_range();
        test_random();
        test_latency1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder that serves load/store requests from the CPU's MEM stage over a valid/ready request channel and a one-cycle response pulse. It replaces the single-cycle combinational data memory path for designs where the pipeline stalls until the memory answers. It holds one outstanding request at a time and models a fixed, parameterised access latency.

## Interface

**Parameters**
- `DEPTH`, 16384: number of 32-bit words. Must be a power of two.
- `LATENCY`, 4: cycles from acceptance to access commit. Must be ≥ 1.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: the single clock; all state changes on its rising edge.
- `reset`, in, 1: synchronous, active-low reset. It is sampled on the rising edge of `clk`. Low means the block is in reset.
- `req_valid`, in, 1: a request is present.
- `req_ready`, out, 1: the block can accept a request.
- `req_write`, in, 1: 1 = store, 0 = load.
- `req_addr`, in, 32: byte address. Bits [1:0] are ignored and the word index is `req_addr[31:2]`.
- `req_wdata`, in, 32: store data.
- `resp_valid`, out, 1: one-cycle pulse marking a completed access.
- `resp_rdata`, out, 32: load data, or the echoed store data.
- `resp_write`, out, 1: the `req_write` value of the completed request.
- `resp_err`, out, 1: the address was out of range. Only meaningful under `MEM_RESP_ADDR_CHECK_EN`.
- `busy`, out, 1: the block is not in IDLE.

## Operation

**State machine:** IDLE → WAIT → RESP → IDLE.
- **IDLE:**
  - `req_ready` = 1 and `busy` = 0.
  - On `req_valid && req_ready`, latch `req_write`, `req_addr[31:2]` and `req_wdata`.
  - Load the countdown with `LATENCY-1` and move to WAIT.
- **WAIT:**
  - `req_ready` = 0.
  - When the countdown is nonzero, decrement it.
  - When the countdown is 0, commit the access on that edge and move to RESP:
    - Store: `mem[idx] <= wdata` and `resp_rdata <= wdata`.
    - Load: `resp_rdata <= mem[idx]`, using the value from before any same-edge write.
- **RESP:**
  - `resp_valid` = 1 for exactly this cycle, with no backpressure.
  - `req_ready` = 0.
  - Next edge moves to IDLE.
- **Response output hold:** `resp_rdata`, `resp_write` and `resp_err` hold their values until the next commit.
- **Request inputs:** inputs are ignored outside IDLE and never re-sampled while busy.
- **Index arithmetic:** the word index uses the low log2(`DEPTH`) bits of `req_addr[31:2]` when in range.

**Reset values** (while `reset` is low at a rising edge):
- State IDLE and countdown 0.
- `resp_valid`, `resp_write` and `resp_err` are 0, and `resp_rdata` is 0.
- `req_ready` is 1 after the reset edge and `busy` is 0.

**Memory contents are not cleared by reset.**

**Reset mid-operation:**
- A request in WAIT is dropped.
- A pending store is not committed.
- No `resp_valid` pulse is issued for it.

## Timing

- **Acceptance to response:** a request accepted at edge N commits at edge N+`LATENCY`, and `resp_valid` is high during the cycle following that edge.
- **Return to IDLE:** the block re-enters IDLE at edge N+`LATENCY`+1.
- **Throughput:** the earliest next acceptance is edge N+`LATENCY`+2, so sustained throughput is one request per `LATENCY`+2 cycles.
- **LATENCY = 1:** WAIT lasts one cycle, and the commit happens at edge N+1.
- **req_ready:** a purely registered-state function with no combinational path from `req_valid`.

## Configuration

**`MEM_RESP_ADDR_CHECK_EN` defined:**
- Any `req_addr[31:2]` ≥ `DEPTH` is out of range.
- On commit of an out-of-range request:
  - `resp_err` = 1.
  - A store is suppressed and memory is unchanged.
  - `resp_rdata` = 0.
- In-range accesses set `resp_err` = 0.

**Not defined:**
- `resp_err` is tied to 0.
- The index wraps modulo `DEPTH`, using the low log2(`DEPTH`) bits, so out-of-range addresses alias onto low words.

## Test plan

1. **Store timing, LATENCY=4:**
   - Stimulus: hold `reset` low for 2 edges, then present a store to 0x10 with data 0xDEADBEEF, accepted at edge 0.
   - Required: `req_ready` is 0 during cycles 1–5; `resp_valid` pulses only in the cycle after edge 4; `resp_write` = 1; `resp_rdata` = 0xDEADBEEF.
2. **Load after store:**
   - Stimulus: load from 0x13 (low bits ignored).
   - Required: `resp_rdata` = 0xDEADBEEF and `resp_write` = 0, 4 edges after acceptance.
3. **Back-to-back requests:**
   - Stimulus: hold `req_valid` high continuously for two loads.
   - Required: acceptances are exactly 6 edges apart at LATENCY=4; each gets exactly one `resp_valid` pulse.
4. **Reset during WAIT:**
   - Stimulus: store 0x1234 to 0x20 (previously 0x5555), then drive `reset` low at edge 2; afterwards load 0x20.
   - Required: no `resp_valid` for the store; the load returns 0x5555; all outputs read their reset values at the reset edge.
5. **Out-of-range address, DEPTH=16384:**
   - Stimulus: store 0xCAFEF00D to 0x0001_0000 (word 16384), then load word 0.
   - Required with the macro: `resp_err` = 1, `resp_rdata` = 0, word 0 unchanged.
   - Required without the macro: `resp_err` = 0, and word 0 reads 0xCAFEF00D.
6. **LATENCY=1:**
   - Stimulus: store then load 0x40 with data 0xA5A5A5A5.
   - Required: `resp_valid` in the cycle after edge N+1, the next acceptance at N+3, and the load returns 0xA5A5A5A5.
